// File: rtl/ola_trigger_pkg.sv
// Shared types and defaults for the logic-analyzer trigger sequencer.
// Optional timeout support is enabled with OLA_TRIGGER_SEQ_TIMEOUT_EN.
package ola_trigger_pkg;

   localparam int DEFAULT_STAGES     = 4;
   localparam int DEFAULT_WIDTH      = 32;
   localparam int DEFAULT_STAGE_BITS = 2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_MATCH,
      DELAY,
      FIRED
   } seq_state_t;

   // One stage-table entry at the default delay width.
   typedef struct packed {
      logic [DEFAULT_WIDTH-1:0] delay;
      logic                     last;
   } stage_entry_t;

endpackage

// File: rtl/ola_trigger_seq_table.sv
// Per-stage table of post-match delays and final-stage flags.
// Writes are dropped while locked; reads are combinational by stage index.
module ola_trigger_seq_table
   import ola_trigger_pkg::*;
#(
   parameter int stages     = DEFAULT_STAGES,
   parameter int width      = DEFAULT_WIDTH,
   parameter int stage_bits = DEFAULT_STAGE_BITS
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic                  wr_lock,
   input  logic [stage_bits-1:0] wr_stage,
   input  logic [width-1:0]      wr_delay,
   input  logic                  wr_last,
   input  logic [stage_bits-1:0] rd_stage,
   output logic [width-1:0]      rd_delay,
   output logic                  rd_last
);

   logic [width-1:0]  delay_q [stages];
   logic [stages-1:0] last_q;

   // Out of reset only the highest stage is marked final.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < stages; i++) begin
            delay_q[i] <= '0;
         end
         last_q <= {1'b1, {(stages-1){1'b0}}};
      end else if (wr_en && !wr_lock && (int'(wr_stage) < stages)) begin
         delay_q[wr_stage] <= wr_delay;
         last_q[wr_stage]  <= wr_last;
      end
   end

   assign rd_delay = delay_q[rd_stage];
   assign rd_last  = last_q[rd_stage];

endmodule

// File: rtl/ola_trigger_sequencer.sv
// Multi-stage trigger sequencer: match, delay, advance, fire one trigger pulse.
// Define OLA_TRIGGER_SEQ_TIMEOUT_EN to add the per-stage match timeout.
module ola_trigger_sequencer
   import ola_trigger_pkg::*;
#(
   parameter int stages     = DEFAULT_STAGES,
   parameter int width      = DEFAULT_WIDTH,
   parameter int stage_bits = DEFAULT_STAGE_BITS
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cfg_write,
   input  logic [stage_bits-1:0] cfg_stage,
   input  logic [width-1:0]      cfg_delay,
   input  logic                  cfg_last,
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
   input  logic [width-1:0]      cfg_timeout,
`endif
   input  logic                  in_arm,
   input  logic                  in_abort,
   input  logic                  in_valid,
   input  logic [stages-1:0]     in_match,
   output logic [stage_bits-1:0] out_stage,
   output logic                  out_armed,
   output logic                  out_delaying,
   output logic                  out_trigger,
   output logic                  out_done,
   output logic                  out_timeout
);

   localparam logic [stage_bits-1:0] LAST_STAGE = stage_bits'(stages - 1);

   seq_state_t       state;
   logic [width-1:0] count;
   logic [width-1:0] tbl_delay;
   logic             tbl_last;
   logic             table_lock;
   logic             hit_match;
   logic             delay_done;
   logic             advance;
   logic             final_stage;

   assign table_lock = (state == WAIT_MATCH) || (state == DELAY);

   ola_trigger_seq_table #(
      .stages     (stages),
      .width      (width),
      .stage_bits (stage_bits)
   ) u_table (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (cfg_write),
      .wr_lock  (table_lock),
      .wr_stage (cfg_stage),
      .wr_delay (cfg_delay),
      .wr_last  (cfg_last),
      .rd_stage (out_stage),
      .rd_delay (tbl_delay),
      .rd_last  (tbl_last)
   );

   // A zero-delay match advances on the matching sample itself.
   always_comb begin
      hit_match   = in_valid && (state == WAIT_MATCH) && in_match[out_stage];
      delay_done  = in_valid && (state == DELAY) && (count == width'(1));
      advance     = (hit_match && (tbl_delay == '0)) || delay_done;
      final_stage = tbl_last || (out_stage == LAST_STAGE);
   end

`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
   logic [width-1:0] tmo_count;
   logic             tmo_active;
   logic             tmo_expire;

   // A match on the expiring sample wins because the timeout only runs without one.
   always_comb begin
      tmo_active = in_valid && (state == WAIT_MATCH) && (out_stage != '0) && !in_match[out_stage];
      tmo_expire = tmo_active && (tmo_count == width'(1));
   end
`else
   assign out_timeout = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         out_stage   <= '0;
         count       <= '0;
         out_trigger <= 1'b0;
         out_done    <= 1'b0;
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
         tmo_count   <= '0;
         out_timeout <= 1'b0;
`endif
      end else begin
         out_trigger <= 1'b0;
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
         out_timeout <= 1'b0;
`endif
         if (in_abort) begin
            state     <= IDLE;
            out_stage <= '0;
            count     <= '0;
            out_done  <= 1'b0;
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
            tmo_count <= '0;
`endif
         end else if (in_arm) begin
            state     <= WAIT_MATCH;
            out_stage <= '0;
            count     <= '0;
            out_done  <= 1'b0;
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
            tmo_count <= '0;
`endif
         end else if (advance) begin
            count <= '0;
            if (final_stage) begin
               state       <= FIRED;
               out_trigger <= 1'b1;
               out_done    <= 1'b1;
            end else begin
               state     <= WAIT_MATCH;
               out_stage <= out_stage + stage_bits'(1);
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
               tmo_count <= cfg_timeout;
`endif
            end
         end else if (hit_match) begin
            count <= tbl_delay;
            state <= DELAY;
         end else if (in_valid && (state == DELAY)) begin
            count <= count - width'(1);
`ifdef OLA_TRIGGER_SEQ_TIMEOUT_EN
         end else if (tmo_expire) begin
            out_stage   <= '0;
            tmo_count   <= '0;
            out_timeout <= 1'b1;
         end else if (tmo_active && (tmo_count != '0)) begin
            tmo_count <= tmo_count - width'(1);
`endif
         end
      end
   end

   assign out_armed    = (state == WAIT_MATCH) || (state == DELAY);
   assign out_delaying = (state == DELAY);

endmodule

// File: doc/ola_trigger_sequencer.md
Name: ola_trigger_sequencer

Overview:
Multi-stage trigger controller for the logic analyzer.
- Holds a small per-stage table of post-match delays.
- Waits for each stage's match qualifier in turn, then runs an internal countdown of sample strobes.
- Advances through the stages and emits a single trigger pulse to the capture controller after the final stage completes.
- Sits between the per-stage comparators and the capture/readout control.

Parameters:
- stages, 4, number of trigger stages (2..16).
- width, 32, delay counter width in samples.
- stage_bits, 2, width of stage index; must satisfy 2**stage_bits >= stages.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_write  in  1  write strobe for the stage table.
- cfg_stage  in  stage_bits  stage index being written.
- cfg_delay  in  width  post-match delay in samples for that stage.
- cfg_last  in  1  marks that stage as final.
- in_arm  in  1  start/restart the sequence at stage 0.
- in_abort  in  1  return to idle.
- in_valid  in  1  sample strobe; all sequencing advances only on it.
- in_match  in  stages  per-stage match qualifier, sampled only with in_valid.
- out_stage  out  stage_bits  current stage index.
- out_armed  out  1  high in WAIT_MATCH or DELAY.
- out_delaying  out  1  high in DELAY.
- out_trigger  out  1  one-cycle pulse on completion.
- out_done  out  1  sticky completion flag.
- out_timeout  out  1  one-cycle timeout pulse (see optional feature).

Behaviour:
- Reset (reset low, asynchronous):
  - state IDLE; all outputs 0; counter 0.
  - Table: all delays 0; cfg_last set only for stage stages-1.
- Table writes:
  - Accepted only in IDLE or FIRED; ignored otherwise.
  - cfg_stage >= stages is ignored.
  - A write takes effect on the next cycle.
- States and transitions:
  - IDLE: in_arm -> WAIT_MATCH, stage 0.
  - WAIT_MATCH: on a cycle where in_valid && in_match[stage]:
    - delay == 0 -> advance in the same cycle.
    - delay != 0 -> load counter = delay, go to DELAY.
  - DELAY:
    - Each in_valid decrements the counter; in_match is ignored.
    - On in_valid with counter == 1 -> advance. Counter reaches 0; no wrap.
    - Advance therefore occurs exactly delay valid samples after the matching sample.
  - Advance:
    - Stage with cfg_last, or stage == stages-1 -> FIRED, with out_trigger high for that one cycle and out_done set.
    - Otherwise -> stage+1, WAIT_MATCH.
  - FIRED: holds. in_arm -> WAIT_MATCH, stage 0, out_done cleared.
- Global controls:
  - in_abort in any state -> IDLE, stage 0, out_done cleared, counter 0.
  - in_abort has priority over in_arm.
  - in_arm in WAIT_MATCH/DELAY restarts at stage 0 and clears the counter.
- Idle strobes: cycles without in_valid change nothing except arm/abort/cfg handling.
- Outputs: registered, no combinational path from inputs. out_stage holds its last value in FIRED.

Optional Feature:
OLA_TRIGGER_SEQ_TIMEOUT_EN
- Enabled:
  - Adds an input port cfg_timeout (width) and a width-bit timeout counter.
  - The counter is reloaded on entry to WAIT_MATCH at any stage > 0.
  - It decrements on in_valid in that state.
  - If it reaches zero without a match: return to WAIT_MATCH stage 0 and pulse out_timeout for one cycle.
  - cfg_timeout == 0 disables the timeout.
  - A match and expiry on the same sample: the match wins.
- Disabled: no timeout logic; out_timeout tied 0; cfg_timeout port absent.

Decomposition:
- Shared package ola_trigger_pkg holds:
  - the state enum (IDLE, WAIT_MATCH, DELAY, FIRED);
  - the default stages/width constants;
  - the stage-table entry struct {delay, last}.
- Sub-module ola_trigger_seq_table: the register array with write-lock input and combinational read by stage index.
- The FSM and counters stay in the top module.

Test Plan:
- Delay loads and counts: stages=4, delays 0,3,0,0, last on stage 3; arm, then match stage 0 on sample 1 -> stage 1 next cycle; match stage 1 -> out_delaying for 3 valid samples, stage 2 after the third; matches 2,3 -> out_trigger exactly one cycle, out_done=1.
- Early final stage: cfg_last on stage 1, delays 0; matches on 0 and 1 -> trigger after stage 1; stage 2 never entered.
- Gapped strobe: in_valid toggled every 3 cycles with delay 2 -> trigger 2 valid samples after the match; counter frozen between strobes.
- Priority and locking: in_arm and in_abort asserted together mid-DELAY -> IDLE, out_done=0; cfg_write while armed -> table unchanged on readback through sequencing.
- Reset mid-DELAY: counter 5, reset pulsed low asynchronously -> all outputs 0 immediately, IDLE; re-arm works.
- Timeout (macro on): cfg_timeout=4, stage 1 waiting, no match for 4 valid samples -> out_timeout pulse, stage 0; match on 4th sample -> advance, no timeout.
